// File: rtl/stack_ram_reader.sv
// stack_ram_reader
//   Storage array and pop-side read path of the stack subsystem. The array is
//   written through the controller's registered RAM write port. Reads are
//   address based: an accepted request goes through a one-cycle read stage
//   and then into a 2-entry output buffer drained with a valid/ready handshake.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst_n     : asynchronous active-low reset (the array itself is not reset)
//   wr_req    : write strobe, mem[wr_addr] <= wr_data
//   wr_addr   : write address
//   wr_data   : write data
//   rd_req    : read request, accepted only while rd_busy is low
//   rd_addr   : read address, sampled with rd_req
//   rd_ready  : consumer takes the head word when high together with rd_valid
//   rd_valid  : rd_data holds a valid word
//   rd_data   : head of the output buffer (holds last shown value when empty)
//   rd_busy   : a new rd_req will not be accepted this cycle
//   err_drop  : sticky, a rd_req arrived while rd_busy was high
module stack_ram_reader #(
    parameter int DEPTH_LOG = 4,
    parameter int WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_req,
    input  logic [DEPTH_LOG-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_req,
    input  logic [DEPTH_LOG-1:0] rd_addr,
    input  logic                 rd_ready,
    output logic                 rd_valid,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_busy,
    output logic                 err_drop
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] stage_q, stage_d;
    logic             inflight_q;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;
    logic             err_q;

    logic accept;
    logic collide;
    logic push;
    logic pop;

    // Busy counts the word in the read stage as already occupying a buffer
    // slot, and deliberately ignores a drain happening in the same cycle.
    assign rd_busy  = (occ_q + {1'b0, inflight_q}) == 2'd2;
    assign rd_valid = (occ_q != 2'd0);
    assign rd_data  = head_q;
    assign err_drop = err_q;

    assign accept  = rd_req && !rd_busy;
    assign collide = wr_req && (wr_addr == rd_addr);
    assign push    = inflight_q;
    assign pop     = rd_valid && rd_ready;

    // Storage array: no reset, contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_req) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read stage: write-first on a same-address collision.
    always_comb begin
        stage_d = stage_q;
        if (accept) begin
            stage_d = collide ? wr_data : mem[rd_addr];
        end
    end

    // Output buffer kept as head/tail registers. The head is left untouched
    // when the last word leaves so rd_data keeps showing it while empty.
    // Push into a full buffer cannot occur because busy blocks it upstream.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b01: begin
                occ_d = occ_q - 2'd1;
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                end
            end
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) begin
                    head_d = stage_q;
                end else begin
                    tail_d = stage_q;
                end
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = stage_q;
                end else begin
                    head_d = tail_q;
                    tail_d = stage_q;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q    <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= 2'd0;
            err_q      <= 1'b0;
        end else begin
            stage_q    <= stage_d;
            inflight_q <= accept;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            if (rd_req && rd_busy) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stack_ram_reader.sv
module tb_stack_ram_reader;

    logic       clk;
    logic       rst_n;
    logic       wr_req;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [3:0] rd_addr;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_busy;
    logic       err_drop;

    stack_ram_reader #(.DEPTH_LOG(4), .WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .err_drop (err_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an array for memory, a queue of words the consumer is
    // owed (tagged with the edge at which the request was accepted) and
    // counters of accepted and consumed reads.
    typedef struct {
        int         tag;
        logic [7:0] d;
    } ent_t;

    ent_t       exp_q[$];
    logic [7:0] mem_m [16];
    int         acc_n   = 0;
    int         pop_n   = 0;
    int         cyc     = 0;
    logic       err_exp = 1'b0;
    logic [7:0] last_exp = 8'h00;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: consumes the expected queue on every handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            last_exp = 8'h00;
        end else begin
            logic exp_vld;
            exp_vld = (exp_q.size() != 0) && (exp_q[0].tag + 1 <= cyc);
            check("rd_valid", {31'b0, rd_valid}, {31'b0, exp_vld});
            if (exp_vld) begin
                check("rd_data", {24'b0, rd_data}, {24'b0, exp_q[0].d});
                if (rd_ready) begin
                    last_exp = exp_q[0].d;
                    void'(exp_q.pop_front());
                    pop_n++;
                end
            end else begin
                check("rd_data_hold", {24'b0, rd_data}, {24'b0, last_exp});
            end
        end
    end

    // One cycle of stimulus; entered and left at posedge+1.
    task automatic drive(input logic wr, input logic [3:0] wa, input logic [7:0] wd,
                         input logic rr, input logic [3:0] ra, input logic rdy);
        logic busy_exp;
        ent_t e;
        busy_exp = ((acc_n - pop_n) == 2);
        check("rd_busy", {31'b0, rd_busy}, {31'b0, busy_exp});
        check("err_drop", {31'b0, err_drop}, {31'b0, err_exp});
        wr_req   = wr;
        wr_addr  = wa;
        wr_data  = wd;
        rd_req   = rr;
        rd_addr  = ra;
        rd_ready = rdy;
        if (rr) begin
            if (busy_exp) begin
                err_exp = 1'b1;
            end else begin
                e.tag = cyc + 1;
                e.d   = (wr && wa == ra) ? wd : mem_m[ra];
                exp_q.push_back(e);
                acc_n++;
            end
        end
        if (wr) mem_m[wa] = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, rdy);
    endtask

    initial begin
        rst_n = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = 1'b0; rd_addr = '0; rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", {31'b0, rd_valid}, 32'd0);
        check("reset_data", {24'b0, rd_data}, 32'd0);
        check("reset_busy", {31'b0, rd_busy}, 32'd0);
        check("reset_err", {31'b0, err_drop}, 32'd0);
        rst_n = 1'b1;
        idle(1, 1'b1);

        // Fill, then read back 15..0 back to back
        for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), 8'hA0 + 8'(i), 1'b0, 4'd0, 1'b1);
        for (int i = 15; i >= 0; i--) drive(1'b0, 4'd0, 8'd0, 1'b1, 4'(i), 1'b1);
        idle(3, 1'b1);

        // Write-first collision
        drive(1'b1, 4'd3, 8'h11, 1'b0, 4'd0, 1'b1);
        drive(1'b1, 4'd3, 8'h5A, 1'b1, 4'd3, 1'b1);
        idle(3, 1'b1);

        // Backpressure: third request dropped
        drive(1'b1, 4'd0, 8'd1, 1'b0, 4'd0, 1'b0);
        drive(1'b1, 4'd1, 8'd2, 1'b0, 4'd0, 1'b0);
        drive(1'b1, 4'd2, 8'd3, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd0, 1'b0);
        drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd1, 1'b0);
        drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd2, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);
        check("bp_drained", exp_q.size(), 32'd0);

        // Steady stream at occupancy 1
        for (int i = 0; i < 20; i++) drive(1'b0, 4'd0, 8'd0, 1'b1, 4'($urandom_range(0, 15)), 1'b1);
        idle(3, 1'b1);
        check("steady_drained", exp_q.size(), 32'd0);

        // Reset in the middle of a read
        drive(1'b1, 4'd7, 8'hC3, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd7, 1'b0);
        rst_n = 1'b0;
        rd_req = 1'b0;
        #1;
        check("midrst_valid", {31'b0, rd_valid}, 32'd0);
        check("midrst_data", {24'b0, rd_data}, 32'd0);
        check("midrst_err", {31'b0, err_drop}, 32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        err_exp = 1'b0;
        acc_n   = pop_n;
        drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd7, 1'b1);
        idle(2, 1'b1);
        check("after_rst_drained", exp_q.size(), 32'd0);
        check("after_rst_last", {24'b0, rd_data}, 32'h0000_00C3);

        // Idle with rd_ready high
        idle(10, 1'b1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 8'($urandom),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1, 1'b1);
        check("final_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
